dsc_con_cache_reader: RTL and testbench

- Read-side controller for the 4-entry x 13-bit DMA descriptor control cache (two-port micro-RAM with registered read address and registered read data).
- Owns the cache read and write pointers and the occupancy count.
- Issues pipelined RAM reads and absorbs the 2-cycle RAM read latency in an output skid buffer.
- Presents cached control words to the DMA channel engine as a valid/ready stream.

---
 rtl/dsc_con_cache_pkg.sv | 26 ++
 rtl/dsc_out_skid_fifo.sv | 58 +++++
 rtl/dsc_con_cache_reader.sv | 143 ++++++++++++++
 tb/tb_dsc_con_cache_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_con_cache_pkg.sv
// Shared widths, depths and types for the DMA descriptor control cache reader.
// Optional overflow flag build switch: DSC_CON_CACHE_OVF_ERR_EN (see top).
// Skid buffer depth is derived from the RAM read latency, never set on its own.
package dsc_con_cache_pkg;

  localparam int DATA_W     = 13;
  localparam int ADDR_W     = 2;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = RD_LAT + 1;
  localparam int SKID_IDX_W = $clog2(SKID_DEPTH);
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int OCC_W      = $clog2(RD_LAT + SKID_DEPTH + 1);

  typedef logic [DATA_W-1:0]     dsc_con_word_t;
  typedef logic [ADDR_W-1:0]     dsc_ptr_t;
  typedef logic [ADDR_W:0]       dsc_lvl_t;
  typedef logic [SKID_IDX_W-1:0] skid_idx_t;
  typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

  // Skid buffer index increment; the buffer is not a power of two deep.
  function automatic skid_idx_t skid_idx_inc(input skid_idx_t idx);
    return (idx == skid_idx_t'(SKID_DEPTH - 1)) ? '0 : idx + skid_idx_t'(1);
  endfunction

endpackage

// File: rtl/dsc_out_skid_fifo.sv
// Output skid buffer: absorbs words already in flight in the RAM read pipe.
// Latency: pushed word becomes head the cycle after push when empty.
// Backpressure: none internally; the caller never issues past free space.
module dsc_out_skid_fifo
  import dsc_con_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] count,
  output logic [DATA_W-1:0]     head
);

  dsc_con_word_t mem [SKID_DEPTH];
  skid_idx_t     wr_idx;
  skid_idx_t     rd_idx;
  skid_cnt_t     cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != skid_cnt_t'(SKID_DEPTH)) || do_pop);

  // Storage is data-only; validity lives entirely in cnt.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Index and occupancy update; reset and clear drop everything held.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_idx <= skid_idx_inc(wr_idx);
      end
      if (do_pop) begin
        rd_idx <= skid_idx_inc(rd_idx);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + skid_cnt_t'(1);
        2'b01:   cnt <= cnt - skid_cnt_t'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign head  = mem[rd_idx];

endmodule

// File: rtl/dsc_con_cache_reader.sv
// Read-side controller for the 4 x 13-bit descriptor control cache; owns pointers and LEVEL.
// Latency: issue at t gives DSC_VALID at t+3 (2-cycle RAM read plus skid capture); 1 word/cycle sustained.
// Backpressure: DSC_READY low stops issue once in-flight plus buffered reaches 3; commits rejected while FULL.
// Build switch DSC_CON_CACHE_OVF_ERR_EN enables the sticky OVF_ERR flag; otherwise it is tied low.
module dsc_con_cache_reader
  import dsc_con_cache_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_COMMIT,
  input  logic              FLUSH,
  output logic [ADDR_W-1:0] RAM_W_ADDR,
  output logic [ADDR_W-1:0] RAM_R_ADDR,
  output logic              RAM_R_ADDR_EN,
  output logic              RAM_R_DATA_EN,
  input  logic [DATA_W-1:0] RAM_R_DATA,
  output logic              DSC_VALID,
  output logic [DATA_W-1:0] DSC_DATA,
  input  logic              DSC_READY,
  output logic [ADDR_W:0]   LEVEL,
  output logic              FULL,
  output logic              OVF_ERR
);

  dsc_ptr_t         wr_ptr;
  dsc_ptr_t         rd_ptr;
  dsc_lvl_t         pending;
  dsc_lvl_t         pending_nxt;
  dsc_lvl_t         level_q;
  dsc_lvl_t         level_nxt;
  logic             full_q;
  logic             s1_vld;
  logic             s2_vld;
  skid_cnt_t        buf_cnt;
  dsc_con_word_t    buf_head;
  logic             pop;
  logic             issue;
  logic             commit_ok;
  logic [OCC_W-1:0] occ_after_pop;

  // A commit in a flush cycle is discarded; FULL is the registered view.
  assign commit_ok = WR_COMMIT && !full_q && !FLUSH;
  assign pop       = (buf_cnt != '0) && DSC_READY;

  // Slots already claimed downstream of the RAM, net of this cycle's pop.
  assign occ_after_pop = OCC_W'(s1_vld) + OCC_W'(s2_vld) + OCC_W'(buf_cnt) - OCC_W'(pop);
  assign issue         = !FLUSH && (pending != '0) && (occ_after_pop < OCC_W'(SKID_DEPTH));

  // Next-state occupancy: pending counts committed-not-issued, level counts committed-not-popped.
  always_comb begin
    pending_nxt = pending;
    level_nxt   = level_q;
    case ({commit_ok, issue})
      2'b10:   pending_nxt = pending + dsc_lvl_t'(1);
      2'b01:   pending_nxt = pending - dsc_lvl_t'(1);
      default: pending_nxt = pending;
    endcase
    case ({commit_ok, pop})
      2'b10:   level_nxt = level_q + dsc_lvl_t'(1);
      2'b01:   level_nxt = level_q - dsc_lvl_t'(1);
      default: level_nxt = level_q;
    endcase
  end

  // Write and read pointers; flush realigns the read side onto the write pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSH) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (commit_ok) begin
        wr_ptr <= wr_ptr + dsc_ptr_t'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + dsc_ptr_t'(1);
      end
    end
  end

  // Valid shadow of the RAM address and data registers.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= issue;
      s2_vld <= s1_vld;
    end
  end

  // Occupancy registers; FULL follows the next LEVEL so both change together.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      pending <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      level_q <= level_nxt;
      full_q  <= (level_nxt == dsc_lvl_t'(DEPTH));
    end
  end

`ifdef DSC_CON_CACHE_OVF_ERR_EN
  logic ovf_q;

  // Sticky record of any commit attempted while full.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      ovf_q <= 1'b0;
    end else if (WR_COMMIT && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign OVF_ERR = ovf_q;
`else
  assign OVF_ERR = 1'b0;
`endif

  dsc_out_skid_fifo u_skid (
    .clk       (CLK),
    .reset     (RESET),
    .clear     (FLUSH),
    .push      (s2_vld),
    .push_data (RAM_R_DATA),
    .pop       (pop),
    .count     (buf_cnt),
    .head      (buf_head)
  );

  assign RAM_W_ADDR    = wr_ptr;
  assign RAM_R_ADDR    = rd_ptr;
  assign RAM_R_ADDR_EN = issue;
  assign RAM_R_DATA_EN = s1_vld;
  assign DSC_VALID     = (buf_cnt != '0);
  assign DSC_DATA      = buf_head;
  assign LEVEL         = level_q;
  assign FULL          = full_q;

endmodule

// File: tb/tb_dsc_con_cache_reader.sv
// Directed bench for dsc_con_cache_reader with a behavioural 4 x 13 cache RAM.
// Expected words, pop cycles and pointer values are hand-derived per scenario.
// OVF_ERR expectation follows DSC_CON_CACHE_OVF_ERR_EN.
module tb_dsc_con_cache_reader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WR_COMMIT;
  logic        FLUSH;
  logic [1:0]  RAM_W_ADDR;
  logic [1:0]  RAM_R_ADDR;
  logic        RAM_R_ADDR_EN;
  logic        RAM_R_DATA_EN;
  logic [12:0] RAM_R_DATA;
  logic        DSC_VALID;
  logic [12:0] DSC_DATA;
  logic        DSC_READY;
  logic [2:0]  LEVEL;
  logic        FULL;
  logic        OVF_ERR;

  logic [12:0] wdata;
  logic [12:0] ram [4];
  logic [1:0]  ram_aq;
  logic [12:0] ram_dq;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_ovf;

`ifdef DSC_CON_CACHE_OVF_ERR_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Cache RAM: writer respects FULL, registered address then registered data.
  always @(posedge CLK) begin
    if (WR_COMMIT && !FULL && !FLUSH) ram[RAM_W_ADDR] <= wdata;
    if (RAM_R_ADDR_EN) ram_aq <= RAM_R_ADDR;
    if (RAM_R_DATA_EN) ram_dq <= ram[ram_aq];
  end
  assign RAM_R_DATA = ram_dq;

  dsc_con_cache_reader dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .WR_COMMIT     (WR_COMMIT),
    .FLUSH         (FLUSH),
    .RAM_W_ADDR    (RAM_W_ADDR),
    .RAM_R_ADDR    (RAM_R_ADDR),
    .RAM_R_ADDR_EN (RAM_R_ADDR_EN),
    .RAM_R_DATA_EN (RAM_R_DATA_EN),
    .RAM_R_DATA    (RAM_R_DATA),
    .DSC_VALID     (DSC_VALID),
    .DSC_DATA      (DSC_DATA),
    .DSC_READY     (DSC_READY),
    .LEVEL         (LEVEL),
    .FULL          (FULL),
    .OVF_ERR       (OVF_ERR)
  );

  task automatic test_reset();
    RESET = 1'b1; WR_COMMIT = 1'b0; FLUSH = 1'b0; DSC_READY = 1'b0; wdata = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    exp_ovf = 1'b0;
    @(negedge CLK);
    n_vec++;
    if ({DSC_VALID, LEVEL, FULL, OVF_ERR, RAM_R_ADDR, RAM_W_ADDR, RAM_R_ADDR_EN, RAM_R_DATA_EN} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required all zero",
               {DSC_VALID, LEVEL, FULL, OVF_ERR, RAM_R_ADDR, RAM_W_ADDR, RAM_R_ADDR_EN, RAM_R_DATA_EN});
    end
  endtask

  task automatic test_fill_order();
    logic [12:0] w [5];
    logic [12:0] q [$];
    int first_issue = -1;
    int first_valid = -1;
    int npop = 0;
    w = '{13'h0A1, 13'h0B2, 13'h0C3, 13'h0D4, 13'h0E5};
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      DSC_READY = 1'b1;
      WR_COMMIT = (i < 5);
      wdata     = '0;
      if (i < 5) wdata = w[i];
      if (i < 4) q.push_back(w[i]);
      if (i == 4) exp_ovf = OVF_EN;
      @(negedge CLK);
      if (RAM_R_ADDR_EN && first_issue < 0) first_issue = i;
      if (DSC_VALID && first_valid < 0) first_valid = i;
      if (i == 4) begin
        n_vec++;
        if ({FULL, RAM_W_ADDR} !== {1'b1, 2'd0}) begin
          n_err++; $display("FAIL fill_full_wrap: got FULL=%b WADDR=%0d required FULL=1 WADDR=0", FULL, RAM_W_ADDR);
        end
      end
      if (i == 5) begin
        n_vec++;
        if (LEVEL !== 3'd3) begin
          n_err++; $display("FAIL fill_reject_level: got %0d required 3", LEVEL);
        end
      end
      if (DSC_VALID && DSC_READY) begin
        n_vec++; npop++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL fill_pop: got %h required no word", DSC_DATA);
        end else begin
          if (DSC_DATA !== q[0]) begin
            n_err++; $display("FAIL fill_pop: got %h required %h", DSC_DATA, q[0]);
          end
          void'(q.pop_front());
        end
      end
    end
    n_vec++;
    if (first_issue != 1 || first_valid != 4) begin
      n_err++; $display("FAIL fill_latency: got issue@%0d valid@%0d required issue@1 valid@4", first_issue, first_valid);
    end
    n_vec++;
    if (npop != 4) begin
      n_err++; $display("FAIL fill_count: got %0d pops required 4", npop);
    end
    n_vec++;
    if ({DSC_VALID, LEVEL, RAM_W_ADDR, RAM_R_ADDR, OVF_ERR} !== {1'b0, 3'd0, 2'd0, 2'd0, exp_ovf}) begin
      n_err++; $display("FAIL fill_end: got V=%b L=%0d W=%0d R=%0d OVF=%b required V=0 L=0 W=0 R=0 OVF=%b",
                        DSC_VALID, LEVEL, RAM_W_ADDR, RAM_R_ADDR, OVF_ERR, exp_ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] q [$];
    logic [1:0]  exp_wptr = 2'd0;
    logic [1:0]  exp_rptr = 2'd0;
    int ncommit = 0;
    int npop = 0;
    int first_pop = -1;
    int last_pop = -1;
    for (int i = 0; i < 34; i++) begin
      @(posedge CLK); #1;
      DSC_READY = 1'b1;
      WR_COMMIT = 1'b0;
      wdata     = '0;
      if (ncommit < 20 && !FULL) begin
        n_vec++;
        if (RAM_W_ADDR !== exp_wptr) begin
          n_err++; $display("FAIL b2b_wptr: got %0d required %0d", RAM_W_ADDR, exp_wptr);
        end
        WR_COMMIT = 1'b1;
        wdata     = 13'h300 + 13'(ncommit);
        q.push_back(wdata);
        exp_wptr  = exp_wptr + 2'd1;
        ncommit++;
      end
      @(negedge CLK);
      if (RAM_R_ADDR_EN) begin
        n_vec++;
        if (RAM_R_ADDR !== exp_rptr) begin
          n_err++; $display("FAIL b2b_rptr: got %0d required %0d", RAM_R_ADDR, exp_rptr);
        end
        exp_rptr = exp_rptr + 2'd1;
      end
      if (DSC_VALID && DSC_READY) begin
        n_vec++; npop++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        if (q.size() == 0) begin
          n_err++; $display("FAIL b2b_pop: got %h required no word", DSC_DATA);
        end else begin
          if (DSC_DATA !== q[0]) begin
            n_err++; $display("FAIL b2b_pop: got %h required %h", DSC_DATA, q[0]);
          end
          void'(q.pop_front());
        end
      end
    end
    n_vec++;
    if (npop != 20 || first_pop != 4 || last_pop != 27) begin
      n_err++; $display("FAIL b2b_timing: got pops=%0d first=%0d last=%0d required 20/4/27", npop, first_pop, last_pop);
    end
    n_vec++;
    if ({LEVEL, RAM_W_ADDR, RAM_R_ADDR} !== {3'd0, 2'd0, 2'd0}) begin
      n_err++; $display("FAIL b2b_end: got L=%0d W=%0d R=%0d required 0/0/0", LEVEL, RAM_W_ADDR, RAM_R_ADDR);
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] w [4];
    logic [12:0] q [$];
    int npop = 0;
    int first_pop = -1;
    int last_pop = -1;
    w = '{13'h111, 13'h122, 13'h133, 13'h144};
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      DSC_READY = (i >= 10);
      WR_COMMIT = (i < 4) || (i == 5);
      wdata     = '0;
      if (i < 4) begin
        wdata = w[i];
        q.push_back(w[i]);
      end
      if (i == 5) begin
        wdata   = 13'h1EE;
        exp_ovf = OVF_EN;
      end
      @(negedge CLK);
      if (i >= 4 && i <= 9) begin
        n_vec++;
        if ({DSC_VALID, DSC_DATA, RAM_R_ADDR_EN, LEVEL, RAM_R_ADDR, FULL} !== {1'b1, 13'h111, 1'b0, 3'd4, 2'd3, 1'b1}) begin
          n_err++; $display("FAIL hold_c%0d: got V=%b D=%h EN=%b L=%0d R=%0d F=%b required V=1 D=111 EN=0 L=4 R=3 F=1",
                            i, DSC_VALID, DSC_DATA, RAM_R_ADDR_EN, LEVEL, RAM_R_ADDR, FULL);
        end
      end
      if (i == 10) begin
        n_vec++;
        if (RAM_R_ADDR_EN !== 1'b1) begin
          n_err++; $display("FAIL release_issue: got %b required 1", RAM_R_ADDR_EN);
        end
      end
      if (DSC_VALID && DSC_READY) begin
        n_vec++; npop++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        if (q.size() == 0) begin
          n_err++; $display("FAIL hold_pop: got %h required no word", DSC_DATA);
        end else begin
          if (DSC_DATA !== q[0]) begin
            n_err++; $display("FAIL hold_pop: got %h required %h", DSC_DATA, q[0]);
          end
          void'(q.pop_front());
        end
      end
    end
    n_vec++;
    if (npop != 4 || first_pop != 10 || last_pop != 13) begin
      n_err++; $display("FAIL hold_release: got pops=%0d first=%0d last=%0d required 4/10/13", npop, first_pop, last_pop);
    end
    n_vec++;
    if ({LEVEL, OVF_ERR} !== {3'd0, exp_ovf}) begin
      n_err++; $display("FAIL hold_end: got L=%0d OVF=%b required L=0 OVF=%b", LEVEL, OVF_ERR, exp_ovf);
    end
  endtask

  task automatic test_flush();
    logic [12:0] w [3];
    logic [12:0] q [$];
    int npop = 0;
    int first_pop = -1;
    w = '{13'h1A1, 13'h1B2, 13'h1C3};
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      DSC_READY = (i >= 4);
      FLUSH     = (i == 3);
      WR_COMMIT = (i <= 4);
      wdata     = '0;
      if (i < 3) wdata = w[i];
      if (i == 3) wdata = 13'h0FF;
      if (i == 4) begin
        wdata   = 13'h1D4;
        q.push_back(wdata);
        exp_ovf = 1'b0;
      end
      @(negedge CLK);
      if (i == 3) begin
        n_vec++;
        if (RAM_R_DATA_EN !== 1'b1) begin
          n_err++; $display("FAIL flush_inflight: got %b required 1", RAM_R_DATA_EN);
        end
      end
      if (i == 4) begin
        n_vec++;
        if ({DSC_VALID, LEVEL, FULL, OVF_ERR, RAM_R_ADDR, RAM_W_ADDR, RAM_R_DATA_EN} !== {1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0}) begin
          n_err++; $display("FAIL flush_state: got V=%b L=%0d F=%b O=%b R=%0d W=%0d DEN=%b required 0/0/0/0/3/3/0",
                            DSC_VALID, LEVEL, FULL, OVF_ERR, RAM_R_ADDR, RAM_W_ADDR, RAM_R_DATA_EN);
        end
      end
      if (i >= 5 && i <= 7) begin
        n_vec++;
        if (DSC_VALID !== 1'b0) begin
          n_err++; $display("FAIL flush_discard_c%0d: got %b required 0", i, DSC_VALID);
        end
      end
      if (DSC_VALID && DSC_READY) begin
        n_vec++; npop++;
        if (first_pop < 0) first_pop = i;
        if (q.size() == 0) begin
          n_err++; $display("FAIL flush_pop: got %h required no word", DSC_DATA);
        end else begin
          if (DSC_DATA !== q[0]) begin
            n_err++; $display("FAIL flush_pop: got %h required %h", DSC_DATA, q[0]);
          end
          void'(q.pop_front());
        end
      end
    end
    n_vec++;
    if (npop != 1 || first_pop != 8 || RAM_W_ADDR !== 2'd0 || LEVEL !== 3'd0) begin
      n_err++; $display("FAIL flush_end: got pops=%0d first=%0d W=%0d L=%0d required 1/8/0/0", npop, first_pop, RAM_W_ADDR, LEVEL);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      DSC_READY = 1'b0;
      FLUSH     = 1'b0;
      RESET     = (i == 4);
      WR_COMMIT = (i < 3);
      wdata     = 13'h2A1 + 13'(i);
      if (i == 4) exp_ovf = 1'b0;
      @(negedge CLK);
      if (i == 4) begin
        n_vec++;
        if (DSC_VALID !== 1'b1) begin
          n_err++; $display("FAIL rst_mid_pre: got %b required 1", DSC_VALID);
        end
      end
      if (i == 5) begin
        n_vec++;
        if ({DSC_VALID, LEVEL, FULL, OVF_ERR, RAM_R_ADDR, RAM_W_ADDR, RAM_R_ADDR_EN, RAM_R_DATA_EN} !== 13'd0) begin
          n_err++; $display("FAIL rst_mid_outputs: got %b required all zero",
                            {DSC_VALID, LEVEL, FULL, OVF_ERR, RAM_R_ADDR, RAM_W_ADDR, RAM_R_ADDR_EN, RAM_R_DATA_EN});
        end
      end
      if (i >= 6) begin
        n_vec++;
        if ({DSC_VALID, RAM_R_DATA_EN, LEVEL} !== 5'd0) begin
          n_err++; $display("FAIL rst_mid_drop_c%0d: got V=%b DEN=%b L=%0d required 0/0/0", i, DSC_VALID, RAM_R_DATA_EN, LEVEL);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_order();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
